// File: rtl/ypbpr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : ypbpr_encoder
//  Description : Three-stage RGB to YPbPr (limited / full range) encoder with
//                vs-synchronised mode switching, blanking and per-channel
//                MSB truncation to DW bits.
//  Revision    : 1.0  initial release
// ============================================================================
module ypbpr_encoder #(
    parameter int DW       = 8,
    parameter bit BLANK_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic            hs_in,
    input  logic            vs_in,
    input  logic            de_in,
    input  logic [23:0]     din,
    output logic            hs_out,
    output logic            vs_out,
    output logic            de_out,
    output logic [3*DW-1:0] dout
);

    localparam logic [1:0] c_MODE_RGB  = 2'd0;
    localparam logic [1:0] c_MODE_LIM  = 2'd1;
    localparam logic [1:0] c_MODE_FULL = 2'd2;

    // ------------------------------------------------------------------
    // Mode latch: sampled only on a vs rising edge; the edge pixel itself
    // already travels with the new mode.
    // ------------------------------------------------------------------
    logic       r_vs_prev;
    logic [1:0] r_mode;
    logic [1:0] w_mode_in;
    logic [1:0] w_mode_cur;
    logic       w_vs_rise;

    // Normalise mode 3 to RGB and select the mode that accompanies this pixel
    always_comb begin
        w_mode_in  = (mode == 2'd3) ? c_MODE_RGB : mode;
        w_vs_rise  = vs_in & ~r_vs_prev;
        w_mode_cur = w_vs_rise ? w_mode_in : r_mode;
    end

    // Previous-vs and active-mode registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vs_prev <= 1'b0;
            r_mode    <= c_MODE_RGB;
        end else begin
            r_vs_prev <= vs_in;
            r_mode    <= w_mode_cur;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: coefficient products (signed, 20 bits, no overflow for 8-bit
    // inputs). RGB, mode and syncs travel alongside.
    // ------------------------------------------------------------------
    logic signed [19:0] w_r, w_g, w_b;
    logic signed [19:0] r_p_yr, r_p_yg, r_p_yb;
    logic signed [19:0] r_p_br, r_p_bg, r_p_bb;
    logic signed [19:0] r_p_rr, r_p_rg, r_p_rb;
    logic [1:0]         r_mode1;
    logic [23:0]        r_rgb1;
    logic [2:0]         r_sync1;

    assign w_r = $signed({12'd0, din[23:16]});
    assign w_g = $signed({12'd0, din[15:8]});
    assign w_b = $signed({12'd0, din[7:0]});

    // Register all nine products of the colour matrix
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_p_yr  <= '0;
            r_p_yg  <= '0;
            r_p_yb  <= '0;
            r_p_br  <= '0;
            r_p_bg  <= '0;
            r_p_bb  <= '0;
            r_p_rr  <= '0;
            r_p_rg  <= '0;
            r_p_rb  <= '0;
            r_mode1 <= c_MODE_RGB;
            r_rgb1  <= '0;
            r_sync1 <= '0;
        end else begin
            r_p_yr  <= w_r * 20'sd263;
            r_p_yg  <= w_g * 20'sd516;
            r_p_yb  <= w_b * 20'sd100;
            r_p_br  <= w_r * (-20'sd152);
            r_p_bg  <= w_g * (-20'sd298);
            r_p_bb  <= w_b * 20'sd450;
            r_p_rr  <= w_r * 20'sd450;
            r_p_rg  <= w_g * (-20'sd377);
            r_p_rb  <= w_b * (-20'sd73);
            r_mode1 <= w_mode_cur;
            r_rgb1  <= din;
            r_sync1 <= {hs_in, vs_in, de_in};
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sum with offset and rounding, shift, clamp to limited range
    // ------------------------------------------------------------------
    logic signed [19:0] w_y_sum, w_pb_sum, w_pr_sum;
    logic signed [19:0] w_y_sh, w_pb_sh, w_pr_sh;
    logic [7:0]         w_y_lim, w_pb_lim, w_pr_lim;
    logic [7:0]         r_y2, r_pb2, r_pr2;
    logic [1:0]         r_mode2;
    logic [23:0]        r_rgb2;
    logic [2:0]         r_sync2;

    // Matrix sums (offset + half LSB) and limited-range clamps
    always_comb begin
        w_y_sum  = 20'sd16896  + r_p_yr + r_p_yg + r_p_yb;
        w_pb_sum = 20'sd131584 + r_p_br + r_p_bg + r_p_bb;
        w_pr_sum = 20'sd131584 + r_p_rr + r_p_rg + r_p_rb;
        w_y_sh   = w_y_sum  >>> 10;
        w_pb_sh  = w_pb_sum >>> 10;
        w_pr_sh  = w_pr_sum >>> 10;

        if (w_y_sh < 20'sd16)        w_y_lim = 8'd16;
        else if (w_y_sh > 20'sd235)  w_y_lim = 8'd235;
        else                         w_y_lim = w_y_sh[7:0];

        if (w_pb_sh < 20'sd16)       w_pb_lim = 8'd16;
        else if (w_pb_sh > 20'sd240) w_pb_lim = 8'd240;
        else                         w_pb_lim = w_pb_sh[7:0];

        if (w_pr_sh < 20'sd16)       w_pr_lim = 8'd16;
        else if (w_pr_sh > 20'sd240) w_pr_lim = 8'd240;
        else                         w_pr_lim = w_pr_sh[7:0];
    end

    // Register limited-range YPbPr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_y2    <= '0;
            r_pb2   <= '0;
            r_pr2   <= '0;
            r_mode2 <= c_MODE_RGB;
            r_rgb2  <= '0;
            r_sync2 <= '0;
        end else begin
            r_y2    <= w_y_lim;
            r_pb2   <= w_pb_lim;
            r_pr2   <= w_pr_lim;
            r_mode2 <= r_mode1;
            r_rgb2  <= r_rgb1;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: full-range expansion, blanking and output mux
    // ------------------------------------------------------------------
    logic signed [19:0] w_yf_p, w_pbf_p, w_prf_p;
    logic signed [19:0] w_yf_s, w_pbf_s, w_prf_s;
    logic [7:0]         w_y_full, w_pb_full, w_pr_full;
    logic [7:0]         w_c2, w_c1, w_c0;
    logic               w_blank;

    // Expand limited values to full range, then pick and blank the channels
    always_comb begin
        w_yf_p  = ($signed({12'd0, r_y2})  - 20'sd16)  * 20'sd298 + 20'sd128;
        w_pbf_p = ($signed({12'd0, r_pb2}) - 20'sd128) * 20'sd291 + 20'sd128;
        w_prf_p = ($signed({12'd0, r_pr2}) - 20'sd128) * 20'sd291 + 20'sd128;
        w_yf_s  = w_yf_p >>> 8;
        w_pbf_s = 20'sd128 + (w_pbf_p >>> 8);
        w_prf_s = 20'sd128 + (w_prf_p >>> 8);

        if (w_yf_s < 20'sd0)          w_y_full = 8'd0;
        else if (w_yf_s > 20'sd255)   w_y_full = 8'd255;
        else                          w_y_full = w_yf_s[7:0];

        if (w_pbf_s < 20'sd0)         w_pb_full = 8'd0;
        else if (w_pbf_s > 20'sd255)  w_pb_full = 8'd255;
        else                          w_pb_full = w_pbf_s[7:0];

        if (w_prf_s < 20'sd0)         w_pr_full = 8'd0;
        else if (w_prf_s > 20'sd255)  w_pr_full = 8'd255;
        else                          w_pr_full = w_prf_s[7:0];

        w_blank = BLANK_EN && !r_sync2[0];

        w_c2 = r_rgb2[23:16];
        w_c1 = r_rgb2[15:8];
        w_c0 = r_rgb2[7:0];
        case (r_mode2)
            c_MODE_LIM: begin
                w_c2 = w_blank ? 8'd128 : r_pr2;
                w_c1 = w_blank ? 8'd16  : r_y2;
                w_c0 = w_blank ? 8'd128 : r_pb2;
            end
            c_MODE_FULL: begin
                w_c2 = w_blank ? 8'd128 : w_pr_full;
                w_c1 = w_blank ? 8'd0   : w_y_full;
                w_c0 = w_blank ? 8'd128 : w_pb_full;
            end
            default: begin
                if (w_blank) begin
                    w_c2 = 8'd0;
                    w_c1 = 8'd0;
                    w_c0 = 8'd0;
                end
            end
        endcase
    end

    // Output registers; each channel keeps its top DW bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout   <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            de_out <= 1'b0;
        end else begin
            dout   <= {w_c2[7 -: DW], w_c1[7 -: DW], w_c0[7 -: DW]};
            hs_out <= r_sync2[2];
            vs_out <= r_sync2[1];
            de_out <= r_sync2[0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ypbpr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ypbpr_encoder
//  Description : Self-checking bench for ypbpr_encoder (DW=8, DW=6 and
//                BLANK_EN=0 instances driven in parallel).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ypbpr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        hs_in, vs_in, de_in;
    logic [23:0] din;

    logic        hs8, vs8, de8;
    logic [23:0] dout8;
    logic        hs6, vs6, de6;
    logic [17:0] dout6;
    logic        hsn, vsn, den;
    logic [23:0] doutn;

    always #5 clk = ~clk;

    ypbpr_encoder #(.DW(8), .BLANK_EN(1'b1)) u_dut8 (
        .clk(clk), .reset(reset), .mode(mode), .hs_in(hs_in), .vs_in(vs_in),
        .de_in(de_in), .din(din), .hs_out(hs8), .vs_out(vs8), .de_out(de8),
        .dout(dout8));

    ypbpr_encoder #(.DW(6), .BLANK_EN(1'b1)) u_dut6 (
        .clk(clk), .reset(reset), .mode(mode), .hs_in(hs_in), .vs_in(vs_in),
        .de_in(de_in), .din(din), .hs_out(hs6), .vs_out(vs6), .de_out(de6),
        .dout(dout6));

    ypbpr_encoder #(.DW(8), .BLANK_EN(1'b0)) u_dutn (
        .clk(clk), .reset(reset), .mode(mode), .hs_in(hs_in), .vs_in(vs_in),
        .de_in(de_in), .din(din), .hs_out(hsn), .vs_out(vsn), .de_out(den),
        .dout(doutn));

    typedef struct {
        logic [23:0] d8;
        logic [17:0] d6;
        logic [23:0] dn;
        logic [2:0]  sync;
    } exp_t;

    typedef struct {
        logic [1:0]  m;
        logic [23:0] d;
        logic        de;
        logic [23:0] e8;
        logic [17:0] e6;
        logic [23:0] en;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_mode;
    bit   m_prev_vs;

    localparam logic [23:0] WHITE = 24'hFFFFFF;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference pixel straight from the conversion formulas
    function automatic logic [23:0] ref_pix(input int md, input logic [23:0] d,
                                            input logic de, input bit ben);
        int r, g, b, y, pb, pr, yf, pbf, prf, m;
        bit blank;
        m = (md == 3) ? 0 : md;
        r = int'(d[23:16]);
        g = int'(d[15:8]);
        b = int'(d[7:0]);
        blank = ben && !de;
        y   = clamp((16896  + 263*r + 516*g + 100*b) >>> 10, 16, 235);
        pb  = clamp((131584 - 152*r - 298*g + 450*b) >>> 10, 16, 240);
        pr  = clamp((131584 + 450*r - 377*g - 73*b)  >>> 10, 16, 240);
        yf  = clamp(((y - 16) * 298 + 128) >>> 8, 0, 255);
        pbf = clamp(128 + (((pb - 128) * 291 + 128) >>> 8), 0, 255);
        prf = clamp(128 + (((pr - 128) * 291 + 128) >>> 8), 0, 255);
        if (m == 0)      return blank ? 24'h000000 : d;
        else if (m == 1) return blank ? 24'h801080 : {pr[7:0], y[7:0], pb[7:0]};
        else             return blank ? 24'h800080 : {prf[7:0], yf[7:0], pbf[7:0]};
    endfunction

    function automatic logic [17:0] trunc6(input logic [23:0] p);
        return {p[23:18], p[15:10], p[7:2]};
    endfunction

    task automatic model_reset();
        exp_t z;
        z.d8 = '0; z.d6 = '0; z.dn = '0; z.sync = '0;
        exp_q.delete();
        exp_q.push_back(z);
        exp_q.push_back(z);
        m_mode    = 0;
        m_prev_vs = 1'b0;
    endtask

    // One pixel clock: drive, update the model on the edge, compare the
    // pixel that entered two edges earlier.
    task automatic cyc(input logic [1:0] m, input logic [23:0] d,
                       input logic h, input logic v, input logic e);
        exp_t x;
        mode = m; din = d; hs_in = h; vs_in = v; de_in = e;
        @(posedge clk);
        if (v && !m_prev_vs) m_mode = int'(m);
        m_prev_vs = v;
        x.d8   = ref_pix(m_mode, d, e, 1'b1);
        x.d6   = trunc6(x.d8);
        x.dn   = ref_pix(m_mode, d, e, 1'b0);
        x.sync = {h, v, e};
        exp_q.push_back(x);
        #1;
        x = exp_q.pop_front();
        chk("pipe_data", {dout8, dout6, doutn}, {x.d8, x.d6, x.dn});
        chk("pipe_sync", {hs8, vs8, de8, hs6, vs6, de6, hsn, vsn, den},
            {x.sync, x.sync, x.sync});
    endtask

    vec_t vt[10];
    logic v_vs;

    initial begin
        vt[0] = '{2'd1, WHITE,        1'b1, 24'h80EB80, {6'd32, 6'd58, 6'd32}, 24'h80EB80};
        vt[1] = '{2'd1, 24'h000000,   1'b1, 24'h801080, {6'd32, 6'd4,  6'd32}, 24'h801080};
        vt[2] = '{2'd1, 24'hFF0000,   1'b1, 24'hF0515A, {6'd60, 6'd20, 6'd22}, 24'hF0515A};
        vt[3] = '{2'd2, 24'hFF0000,   1'b1, 24'hFF4C55, {6'd63, 6'd19, 6'd21}, 24'hFF4C55};
        vt[4] = '{2'd2, WHITE,        1'b0, 24'h800080, {6'd32, 6'd0,  6'd32}, 24'h80FF80};
        vt[5] = '{2'd0, WHITE,        1'b0, 24'h000000, 18'd0,                 24'hFFFFFF};
        vt[6] = '{2'd0, 24'h123456,   1'b1, 24'h123456, {6'd4,  6'd13, 6'd21}, 24'h123456};
        vt[7] = '{2'd3, 24'h123456,   1'b1, 24'h123456, {6'd4,  6'd13, 6'd21}, 24'h123456};
        vt[8] = '{2'd1, WHITE,        1'b0, 24'h801080, {6'd32, 6'd4,  6'd32}, 24'h80EB80};
        vt[9] = '{2'd2, WHITE,        1'b1, 24'h80FF80, {6'd32, 6'd63, 6'd32}, 24'h80FF80};

        reset = 1'b1; mode = 2'd0; din = '0; hs_in = 0; vs_in = 0; de_in = 0;
        #12;
        chk("reset_state", {dout8, dout6, doutn, hs8, vs8, de8, hsn, vsn, den}, '0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Directed vectors: latch the mode with a vs edge on the pixel itself
        for (int i = 0; i < 10; i++) begin
            cyc(vt[i].m, vt[i].d, 1'b0, 1'b1, vt[i].de);
            cyc(vt[i].m, 24'h0, 1'b0, 1'b0, 1'b0);
            cyc(vt[i].m, 24'h0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("vec%0d_dw8", i), dout8, vt[i].e8);
            chk($sformatf("vec%0d_dw6", i), dout6, vt[i].e6);
            chk($sformatf("vec%0d_noblank", i), doutn, vt[i].en);
        end

        // Randomised traffic with occasional vs edges and mode changes
        v_vs = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) v_vs = ~v_vs;
            cyc(2'($urandom_range(0, 3)), 24'($urandom), 1'($urandom_range(0, 1)),
                v_vs, ($urandom_range(0, 3) != 0));
        end

        // Mode change without a vs edge, then the edge
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, WHITE, 0, 0, 1);
        cyc(1, WHITE, 0, 0, 1);
        cyc(1, WHITE, 0, 0, 1);
        chk("no_edge_p0", dout8, WHITE);
        cyc(1, WHITE, 0, 1, 1);
        chk("no_edge_p1", dout8, WHITE);
        cyc(1, WHITE, 0, 1, 1);
        chk("no_edge_p2", dout8, WHITE);
        cyc(1, 0, 0, 0, 0);
        chk("edge_pix", dout8, 24'h80EB80);
        cyc(1, 0, 0, 0, 0);
        chk("after_edge_pix", dout8, 24'h80EB80);

        // Single-cycle sync pulse emerges exactly three edges later
        cyc(1, 0, 1, 1, 1);
        chk("sync_d1", {hs6, vs6, de6}, 3'b000);
        cyc(1, 0, 0, 0, 0);
        chk("sync_d2", {hs6, vs6, de6}, 3'b000);
        cyc(1, 0, 0, 0, 0);
        chk("sync_d3", {hs6, vs6, de6}, 3'b111);
        cyc(1, 0, 0, 0, 0);
        chk("sync_d4", {hs6, vs6, de6}, 3'b000);

        // Reset with the pipe full of YPbPr pixels
        cyc(1, WHITE, 0, 1, 1);
        cyc(1, WHITE, 0, 0, 1);
        cyc(1, WHITE, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_async", {dout8, dout6, doutn, hs8, vs8, de8, hs6, vs6, de6, hsn, vsn, den}, '0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        cyc(1, WHITE, 0, 0, 1);
        cyc(1, WHITE, 0, 0, 1);
        cyc(1, WHITE, 0, 0, 1);
        chk("rgb_after_rst", dout8, WHITE);
        cyc(1, WHITE, 0, 1, 1);
        cyc(1, WHITE, 0, 1, 1);
        cyc(1, WHITE, 0, 1, 1);
        chk("ypbpr_after_vs", dout8, 24'h80EB80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
